ps2_key_event_decoder: RTL and testbench
========================================

Name: ps2_key_event_decoder

Overview:
- Consumes the raw byte stream from the PS/2 controller (received_data / received_data_en) and parses keyboard scan-code set 2.
- Handles the E0 extended prefix, the F0 break prefix and the E1 pause sequence.
- Emits make/break key events through a small ready/valid FIFO.
- Maintains a debounced "held" bitmap for the five game-lane keys used by the note-hit logic downstream.

Parameters:
- FIFO_DEPTH, 4, event FIFO entries; power of two, 2..16.
- TIMEOUT_CYCLES, 5000000, CLOCK_50 cycles (100 ms) allowed between prefix and final byte before the partial sequence is discarded.
- LANE0_CODE, 8'h1C, non-extended scan code for lane 0 ('A').
- LANE1_CODE, 8'h1B, lane 1 ('S').
- LANE2_CODE, 8'h23, lane 2 ('D').
- LANE3_CODE, 8'h2B, lane 3 ('F').
- LANE4_CODE, 8'h29, lane 4 (space).

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high.
- received_data  in  16  byte from the PS/2 controller; only [7:0] is used, [15:8] is ignored.
- received_data_en  in  1  one-cycle strobe; byte valid this cycle.
- evt_valid  out  1  FIFO non-empty.
- evt_ready  in  1  consumer accepts the head entry.
- evt_code  out  8  head entry scan code.
- evt_ext  out  1  head entry had the E0 prefix.
- evt_break  out  1  head entry is a release (F0 seen).
- lane_held  out  5  bit i = lane i currently held.
- overflow  out  1  sticky flag: an event was dropped because the FIFO was full.
- clear_overflow  in  1  clears overflow.

Behaviour:
Reset:
- Synchronous, active-high, clock CLOCK_50.
- FIFO empty; evt_valid=0; evt_code/evt_ext/evt_break=0; lane_held=0; overflow=0; parser in IDLE; timeout and skip counters = 0.
- Reset asserted mid-sequence discards all partial state.

Parser FSM (advances only on cycles with received_data_en=1, except the timeout):
- IDLE:
  - E0 -> EXT.
  - F0 -> BRK.
  - E1 -> SKIP, skip count = 7.
  - 00, AA, EE, FA, FC, FD, FE, FF are ignored.
  - Any other byte produces a make event {code, ext=0, brk=0}; stay in IDLE.
- EXT:
  - F0 -> EXT_BRK.
  - E0 is ignored (stay in EXT).
  - Any other byte produces a make event {code, ext=1}; go to IDLE.
- BRK: any byte produces a break event {code, ext=0, brk=1}; go to IDLE.
- EXT_BRK: any byte produces a break event {code, ext=1, brk=1}; go to IDLE.
- SKIP: decrement the count on each byte; return to IDLE when the byte that takes the count to 0 arrives. No event is produced.

Timeout:
- The counter clears on every accepted byte and in IDLE.
- In EXT/BRK/EXT_BRK/SKIP it increments each cycle.
- At TIMEOUT_CYCLES-1 the FSM goes to IDLE with no event.
- A byte arriving on the same cycle as the timeout is processed by the current state; the byte wins.

Event generation and latency:
- The event is formed in the cycle the final byte's strobe is seen.
- It is written to the FIFO and lane_held updates on the next edge.
- evt_valid rises 1 cycle after the strobe when the FIFO was empty.

Lane logic (ext=0 codes only; an E0-prefixed code never matches a lane):
- Make on a lane whose held bit is 0: set the bit and push the event.
- Make on a lane whose held bit is 1 (typematic repeat): no push, bit unchanged.
- Break on a lane: clear the bit and push the event, even if the bit was already 0.
- Unmapped codes: always pushed, no repeat filtering.

FIFO:
- First-word-fall-through: evt_* show the head entry whenever evt_valid=1.
- A pop happens when evt_valid && evt_ready.
- Push while full without a same-cycle pop: the event is dropped, overflow sets, and lane_held still updates.
- Push while full with a same-cycle pop: both succeed; the entry count is unchanged.
- Pop when empty: no effect.
- Pointers wrap modulo FIFO_DEPTH; the count is log2(FIFO_DEPTH)+1 bits wide.

Overflow flag:
- clear_overflow clears overflow.
- A set and a clear on the same cycle: set wins.

Decomposition:
- Shared package ps2_kbd_pkg holds:
  - parser state enum (IDLE, EXT, BRK, EXT_BRK, SKIP);
  - byte constants PS2_PFX_EXT=8'hE0, PS2_PFX_BRK=8'hF0, PS2_PFX_PAUSE=8'hE1, PS2_PAUSE_TAIL=7;
  - the ignored-byte list;
  - a 10-bit key_event_t {code[7:0], ext, brk}.
- One sub-module, ps2_event_fifo: a parameterised FWFT synchronous FIFO of key_event_t with full/empty signals. Parser, lane logic and timeout stay in the top module.

Test Plan:
1. Bytes 1C, F0 1C with evt_ready=1 -> events {1C,0,0} then {1C,0,1}; lane_held[0] goes 1 one cycle after the first strobe, then 0 one cycle after the final 1C.
2. Bytes E0 75, E0 F0 75 -> events {75,1,0} and {75,1,1}; lane_held stays 0.
3. Typematic repeat: 23 ×5 then F0 23 -> exactly two events (make, break); lane_held[2] is high between them.
4. Pause sequence E1 14 77 E1 F0 14 F0 77, then 2B -> only {2B,0,0} is emitted.
5. evt_ready=0 with 6 distinct unmapped makes (FIFO_DEPTH=4) -> 4 entries held, overflow=1. Raising evt_ready drains the entries in order; clear_overflow returns overflow to 0.
6. Timeout and reset:
   - Byte F0 then idle for TIMEOUT_CYCLES (bench parameter 100) then 1C -> make {1C,0,0}, not a break.
   - Reset asserted after E0 -> the next 1C yields {1C,0,0}.

Source files
------------

// File: rtl/ps2_kbd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ps2_kbd_pkg
// Description : Shared types and constants for the PS/2 scan-code set 2
//               key-event decoder: parser state enum, prefix bytes, the
//               list of controller/keyboard status bytes that carry no key
//               information, and the packed key event record.
// Revision    : 1.0 - initial release
// ============================================================================
package ps2_kbd_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        EXT     = 3'd1,
        BRK     = 3'd2,
        EXT_BRK = 3'd3,
        SKIP    = 3'd4
    } parser_state_t;

    localparam logic [7:0] PS2_PFX_EXT    = 8'hE0;
    localparam logic [7:0] PS2_PFX_BRK    = 8'hF0;
    localparam logic [7:0] PS2_PFX_PAUSE  = 8'hE1;
    // Bytes that follow E1 in the pause make sequence (E1 14 77 E1 F0 14 F0 77).
    localparam logic [2:0] PS2_PAUSE_TAIL = 3'd7;

    // Status / acknowledge / error bytes: buffer overrun, BAT ok, echo, ack,
    // BAT fail, resend and error. None of them are key codes.
    localparam int         PS2_NUM_IGNORED   = 8;
    localparam logic [63:0] PS2_IGNORED_BYTES = {
        8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF
    };

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } key_event_t;

    function automatic logic ps2_is_ignored(input logic [7:0] b);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < PS2_NUM_IGNORED; i++) begin
            if (b == PS2_IGNORED_BYTES[i*8 +: 8]) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_event_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ps2_event_fifo
// Description : First-word-fall-through synchronous FIFO of key_event_t.
//               o_data presents the head entry whenever the FIFO is not
//               empty and reads as zero when it is empty. A push into a full
//               FIFO is accepted only if a pop happens in the same cycle.
// Ports       : clk, rst       - clock, synchronous active-high reset
//               i_push, i_data - write request and entry
//               i_pop          - consume head (ignored when empty)
//               o_data         - head entry
//               o_full/o_empty - occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_event_fifo
    import ps2_kbd_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_push,
    input  key_event_t i_data,
    input  logic       i_pop,
    output key_event_t o_data,
    output logic       o_full,
    output logic       o_empty
);

    localparam int            AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   c_FULL_CNT  = (AW+1)'(DEPTH);

    key_event_t    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic w_pop;
    logic w_push;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == c_FULL_CNT);
    assign w_pop   = i_pop && !o_empty;
    // A full FIFO frees a slot in the same edge it is popped.
    assign w_push  = i_push && (!o_full || w_pop);

    assign o_data  = o_empty ? key_event_t'('0) : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // DEPTH is a power of two, so pointer wrap is the natural AW-bit rollover.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/ps2_key_event_decoder.sv
`default_nettype none
// ============================================================================
// Module      : ps2_key_event_decoder
// Description : Parses the PS/2 scan-code set 2 byte stream (E0 extended,
//               F0 break and E1 pause sequences) into make/break key events
//               delivered through a ready/valid FWFT FIFO, and tracks the
//               held state of the five game-lane keys with typematic-repeat
//               filtering on those lanes.
// Ports       : CLOCK_50, reset          - clock, synchronous active-high reset
//               received_data[7:0]       - byte from PS/2 controller
//               received_data_en         - byte strobe
//               evt_valid/evt_ready      - event handshake
//               evt_code/evt_ext/evt_break - head event fields
//               lane_held[4:0]           - lane key held bitmap
//               overflow, clear_overflow - sticky drop flag and its clear
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_key_event_decoder
    import ps2_kbd_pkg::*;
#(
    parameter int         FIFO_DEPTH     = 4,
    parameter int         TIMEOUT_CYCLES = 5000000,
    parameter logic [7:0] LANE0_CODE     = 8'h1C,
    parameter logic [7:0] LANE1_CODE     = 8'h1B,
    parameter logic [7:0] LANE2_CODE     = 8'h23,
    parameter logic [7:0] LANE3_CODE     = 8'h2B,
    parameter logic [7:0] LANE4_CODE     = 8'h29
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic [15:0] received_data,
    input  logic        received_data_en,
    output logic        evt_valid,
    input  logic        evt_ready,
    output logic [7:0]  evt_code,
    output logic        evt_ext,
    output logic        evt_break,
    output logic [4:0]  lane_held,
    output logic        overflow,
    input  logic        clear_overflow
);

    localparam int            TW           = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] c_TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [39:0]   c_LANE_CODES = {LANE4_CODE, LANE3_CODE, LANE2_CODE,
                                              LANE1_CODE, LANE0_CODE};

    parser_state_t r_state;
    parser_state_t w_state_nxt;
    logic [2:0]    r_skip;
    logic [2:0]    w_skip_nxt;
    logic [TW-1:0] r_tmo;
    logic [TW-1:0] w_tmo_nxt;

    logic [7:0]    w_byte;
    logic          w_unused_hi;
    logic          w_evt_fire;
    key_event_t    w_evt;

    logic [4:0]    r_lane_held;
    logic [4:0]    w_lane_nxt;
    logic [4:0]    w_lane_match;
    logic          w_repeat;
    logic          w_push;

    key_event_t    w_head;
    logic          w_full;
    logic          w_empty;
    logic          w_pop;
    logic          w_drop;
    logic          r_overflow;

    assign w_byte      = received_data[7:0];
    assign w_unused_hi = ^received_data[15:8];

    // ------------------------------------------------------------------
    // Parser: state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state <= IDLE;
            r_skip  <= '0;
            r_tmo   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_skip  <= w_skip_nxt;
            r_tmo   <= w_tmo_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Parser: next state, event formation, timeout.
    // A byte arriving on the timeout cycle is handled by the current state;
    // the timeout only applies on cycles without a strobe.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_skip_nxt  = r_skip;
        w_tmo_nxt   = r_tmo;
        w_evt_fire  = 1'b0;
        w_evt       = '0;

        if (received_data_en) begin
            w_tmo_nxt = '0;
            case (r_state)
                IDLE: begin
                    if (w_byte == PS2_PFX_EXT) begin
                        w_state_nxt = EXT;
                    end else if (w_byte == PS2_PFX_BRK) begin
                        w_state_nxt = BRK;
                    end else if (w_byte == PS2_PFX_PAUSE) begin
                        w_state_nxt = SKIP;
                        w_skip_nxt  = PS2_PAUSE_TAIL;
                    end else if (!ps2_is_ignored(w_byte)) begin
                        w_evt_fire = 1'b1;
                        w_evt.code = w_byte;
                    end
                end
                EXT: begin
                    if (w_byte == PS2_PFX_BRK) begin
                        w_state_nxt = EXT_BRK;
                    end else if (w_byte != PS2_PFX_EXT) begin
                        // Repeated E0 is tolerated and leaves us in EXT.
                        w_evt_fire  = 1'b1;
                        w_evt.code  = w_byte;
                        w_evt.ext   = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
                BRK: begin
                    w_evt_fire  = 1'b1;
                    w_evt.code  = w_byte;
                    w_evt.brk   = 1'b1;
                    w_state_nxt = IDLE;
                end
                EXT_BRK: begin
                    w_evt_fire  = 1'b1;
                    w_evt.code  = w_byte;
                    w_evt.ext   = 1'b1;
                    w_evt.brk   = 1'b1;
                    w_state_nxt = IDLE;
                end
                SKIP: begin
                    if (r_skip <= 3'd1) begin
                        w_skip_nxt  = '0;
                        w_state_nxt = IDLE;
                    end else begin
                        w_skip_nxt  = r_skip - 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_skip_nxt  = '0;
                end
            endcase
        end else if (r_state == IDLE) begin
            w_tmo_nxt = '0;
        end else if (r_tmo == c_TMO_LAST) begin
            // Partial sequence took too long: drop it silently.
            w_state_nxt = IDLE;
            w_skip_nxt  = '0;
            w_tmo_nxt   = '0;
        end else begin
            w_tmo_nxt   = r_tmo + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Lane tracking. Extended codes never map to a lane.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < 5; gi++) begin : g_lane
        assign w_lane_match[gi] = w_evt_fire && !w_evt.ext &&
                                  (w_evt.code == c_LANE_CODES[gi*8 +: 8]);
    end

    // A make on an already-held lane is keyboard typematic repeat.
    assign w_repeat = !w_evt.brk && (|(w_lane_match & r_lane_held));
    assign w_push   = w_evt_fire && !w_repeat;

    always_comb begin
        w_lane_nxt = r_lane_held;
        if (w_evt_fire) begin
            if (w_evt.brk) begin
                w_lane_nxt = r_lane_held & ~w_lane_match;
            end else begin
                w_lane_nxt = r_lane_held | w_lane_match;
            end
        end
    end

    // Lane state follows the keyboard even when the FIFO drops the event.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_lane_held <= '0;
        end else begin
            r_lane_held <= w_lane_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Event FIFO and overflow flag
    // ------------------------------------------------------------------
    ps2_event_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk     (CLOCK_50),
        .rst     (reset),
        .i_push  (w_push),
        .i_data  (w_evt),
        .i_pop   (evt_ready),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_pop  = !w_empty && evt_ready;
    assign w_drop = w_push && w_full && !w_pop;

    // Set has priority over a simultaneous clear.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (clear_overflow) begin
            r_overflow <= 1'b0;
        end
    end

    assign evt_valid = !w_empty;
    assign evt_code  = w_head.code;
    assign evt_ext   = w_head.ext;
    assign evt_break = w_head.brk;
    assign lane_held = r_lane_held;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_event_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_key_event_decoder
// Description : Self-checking bench for ps2_key_event_decoder. A queue-based
//               reference model predicts the FIFO contents, lane bitmap and
//               overflow flag; outputs are compared every cycle, with
//               directed sequences followed by randomized byte streams.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_key_event_decoder;

    localparam int DEPTH = 4;
    localparam int TMO   = 100;

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic [15:0] received_data;
    logic        received_data_en;
    logic        evt_valid;
    logic        evt_ready;
    logic [7:0]  evt_code;
    logic        evt_ext;
    logic        evt_break;
    logic [4:0]  lane_held;
    logic        overflow;
    logic        clear_overflow;

    always #10 CLOCK_50 = ~CLOCK_50;

    ps2_key_event_decoder #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .CLOCK_50         (CLOCK_50),
        .reset            (reset),
        .received_data    (received_data),
        .received_data_en (received_data_en),
        .evt_valid        (evt_valid),
        .evt_ready        (evt_ready),
        .evt_code         (evt_code),
        .evt_ext          (evt_ext),
        .evt_break        (evt_break),
        .lane_held        (lane_held),
        .overflow         (overflow),
        .clear_overflow   (clear_overflow)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;
    bit rnd_mode = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model. Events are {code, ext, brk} packed into 10 bits.
    // ------------------------------------------------------------------
    logic [7:0] lanes [5]   = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h29};
    logic [7:0] ignored [8] = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF};

    logic [9:0] q [$];
    logic [9:0] mlog [$];
    logic [4:0] m_held = '0;
    bit         m_ovf  = 1'b0;
    bit         m_ext, m_brk;
    int         m_skip;
    longint     cyc = 0;
    longint     m_last = 0;

    function automatic bit is_ign(input logic [7:0] b);
        foreach (ignored[i]) if (ignored[i] == b) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int lane_of(input logic [7:0] b);
        foreach (lanes[i]) if (lanes[i] == b) return i;
        return -1;
    endfunction

    always @(posedge CLOCK_50) begin
        bit         have, pop, push, set_ovf;
        logic [9:0] e;
        logic [7:0] b;
        int         sz, ln;
        cyc++;
        if (reset) begin
            q.delete();
            m_held = '0; m_ovf = 1'b0;
            m_ext = 1'b0; m_brk = 1'b0; m_skip = 0;
        end else begin
            have = 1'b0; e = '0; set_ovf = 1'b0;
            sz   = q.size();
            pop  = (sz > 0) && evt_ready;
            if (received_data_en) begin
                b = received_data[7:0];
                if ((m_ext || m_brk || m_skip > 0) && (cyc - m_last > TMO)) begin
                    m_ext = 1'b0; m_brk = 1'b0; m_skip = 0;
                end
                m_last = cyc;
                if (m_skip > 0) begin
                    m_skip--;
                end else if (m_brk) begin
                    have = 1'b1; e = {b, m_ext, 1'b1};
                    m_ext = 1'b0; m_brk = 1'b0;
                end else if (m_ext) begin
                    if (b == 8'hF0) m_brk = 1'b1;
                    else if (b != 8'hE0) begin
                        have = 1'b1; e = {b, 1'b1, 1'b0}; m_ext = 1'b0;
                    end
                end else begin
                    if (b == 8'hE0) m_ext = 1'b1;
                    else if (b == 8'hF0) m_brk = 1'b1;
                    else if (b == 8'hE1) m_skip = 7;
                    else if (!is_ign(b)) begin
                        have = 1'b1; e = {b, 2'b00};
                    end
                end
            end
            push = have;
            if (have && !e[1]) begin
                ln = lane_of(e[9:2]);
                if (ln >= 0) begin
                    if (e[0]) m_held[ln] = 1'b0;
                    else if (m_held[ln]) push = 1'b0;
                    else m_held[ln] = 1'b1;
                end
            end
            if (pop) mlog.push_back(q.pop_front());
            if (push) begin
                if (sz < DEPTH || pop) q.push_back(e);
                else set_ovf = 1'b1;
            end
            if (set_ovf) m_ovf = 1'b1;
            else if (clear_overflow) m_ovf = 1'b0;
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge CLOCK_50) begin
        if (cmp_en) begin
            chk("evt_valid", {31'd0, evt_valid}, {31'd0, q.size() != 0});
            if (q.size() != 0) begin
                chk("evt_code",  {24'd0, evt_code},  {24'd0, q[0][9:2]});
                chk("evt_ext",   {31'd0, evt_ext},   {31'd0, q[0][1]});
                chk("evt_break", {31'd0, evt_break}, {31'd0, q[0][0]});
            end
            chk("lane_held", {27'd0, lane_held}, {27'd0, m_held});
            chk("overflow",  {31'd0, overflow},  {31'd0, m_ovf});
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic step(input logic en, input logic [7:0] b);
        @(negedge CLOCK_50);
        received_data_en = en;
        received_data    = {8'($urandom), en ? b : 8'($urandom)};
        if (rnd_mode) begin
            evt_ready      = ($urandom_range(0, 3) != 0);
            clear_overflow = ($urandom_range(0, 15) == 0);
        end
    endtask

    task automatic send(input logic [7:0] b);
        step(1'b1, b);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 8'h00);
    endtask

    task automatic chk_log(input string nm, input int idx, input logic [9:0] exp);
        logic [31:0] act;
        act = (idx < mlog.size()) ? {22'd0, mlog[idx]} : 32'hDEAD;
        chk(nm, act, {22'd0, exp});
    endtask

    logic [7:0] t5 [6] = '{8'h15, 8'h16, 8'h1D, 8'h24, 8'h2D, 8'h2C};
    logic [7:0] pause_seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

    initial begin
        reset = 1'b1; received_data_en = 1'b0; received_data = '0;
        evt_ready = 1'b1; clear_overflow = 1'b0;
        idle(3);
        chk("rst_valid", {31'd0, evt_valid}, 32'd0);
        chk("rst_code",  {24'd0, evt_code},  32'd0);
        chk("rst_ext",   {31'd0, evt_ext},   32'd0);
        chk("rst_break", {31'd0, evt_break}, 32'd0);
        chk("rst_lane",  {27'd0, lane_held}, 32'd0);
        chk("rst_ovf",   {31'd0, overflow},  32'd0);
        cmp_en = 1'b1;
        reset  = 1'b0;
        idle(2);

        // 1: make / break on lane 0
        mlog.delete();
        send(8'h1C); idle(1);
        chk("t1_held_set", {27'd0, lane_held}, 32'd1);
        send(8'hF0); send(8'h1C); idle(1);
        chk("t1_held_clr", {27'd0, lane_held}, 32'd0);
        idle(2);
        chk("t1_log_n", mlog.size(), 32'd2);
        chk_log("t1_ev0", 0, {8'h1C, 2'b00});
        chk_log("t1_ev1", 1, {8'h1C, 2'b01});

        // 2: extended make / break never touches lanes
        mlog.delete();
        send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75); idle(3);
        chk("t2_log_n", mlog.size(), 32'd2);
        chk_log("t2_ev0", 0, {8'h75, 2'b10});
        chk_log("t2_ev1", 1, {8'h75, 2'b11});
        chk("t2_held", {27'd0, lane_held}, 32'd0);

        // 3: typematic repeat filtering
        mlog.delete();
        repeat (5) send(8'h23);
        idle(1);
        chk("t3_held", {27'd0, lane_held}, 32'd4);
        send(8'hF0); send(8'h23); idle(3);
        chk("t3_log_n", mlog.size(), 32'd2);
        chk_log("t3_ev0", 0, {8'h23, 2'b00});
        chk_log("t3_ev1", 1, {8'h23, 2'b01});

        // 4: pause sequence swallowed
        mlog.delete();
        foreach (pause_seq[i]) send(pause_seq[i]);
        send(8'h2B); idle(3);
        chk("t4_log_n", mlog.size(), 32'd1);
        chk_log("t4_ev0", 0, {8'h2B, 2'b00});
        send(8'hF0); send(8'h2B); idle(3);

        // 5: overflow with consumer stalled, then drain in order
        evt_ready = 1'b0;
        foreach (t5[i]) send(t5[i]);
        idle(2);
        chk("t5_ovf",   {31'd0, overflow},  32'd1);
        chk("t5_valid", {31'd0, evt_valid}, 32'd1);
        chk("t5_head",  {24'd0, evt_code},  32'h15);
        mlog.delete();
        evt_ready = 1'b1;
        idle(6);
        chk("t5_log_n", mlog.size(), 32'd4);
        for (int i = 0; i < 4; i++) chk_log("t5_drain", i, {t5[i], 2'b00});
        chk("t5_empty", {31'd0, evt_valid}, 32'd0);
        clear_overflow = 1'b1; idle(1); clear_overflow = 1'b0; idle(1);
        chk("t5_ovf_clr", {31'd0, overflow}, 32'd0);

        // 6a: break prefix times out
        mlog.delete();
        send(8'hF0); idle(TMO); send(8'h1C); idle(3);
        chk("t6_log_n", mlog.size(), 32'd1);
        chk_log("t6_ev0", 0, {8'h1C, 2'b00});

        // 6b: reset mid-sequence
        send(8'hE0);
        reset = 1'b1; idle(2); reset = 1'b0;
        mlog.delete();
        send(8'h1C); idle(3);
        chk("t6r_log_n", mlog.size(), 32'd1);
        chk_log("t6r_ev0", 0, {8'h1C, 2'b00});

        // Randomized streams
        rnd_mode = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            int r;
            logic [7:0] b;
            r = $urandom_range(0, 19);
            if (r < 5)       b = lanes[r];
            else if (r < 7)  b = 8'hF0;
            else if (r == 7) b = 8'hE0;
            else if (r == 8) b = 8'hE1;
            else if (r == 9) b = ignored[$urandom_range(0, 7)];
            else             b = 8'($urandom);
            send(b);
            if ($urandom_range(0, 39) == 0) idle($urandom_range(TMO - 5, TMO + 10));
            else idle($urandom_range(0, 3));
            if ($urandom_range(0, 299) == 0) begin
                reset = 1'b1; idle(2); reset = 1'b0;
            end
        end
        rnd_mode = 1'b0;
        evt_ready = 1'b1; clear_overflow = 1'b0;
        idle(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
